// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC and drives a 1-cycle-latency instruction ROM.
// Optional halt-on-self-jump detection under IFETCH_HALT_DETECT_EN.
module instruction_fetch #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump_taken,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid
`ifdef IFETCH_HALT_DETECT_EN
  ,
  output logic              halted
`endif
);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] cur_pc;
  logic              valid_q;
  logic              frozen;
  logic              take_jump;

  assign take_jump = valid_q & jump_taken;

`ifdef IFETCH_HALT_DETECT_EN
  logic halt_q;

  // Hack programs end in a self-loop; park the stage once it is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q <= 1'b0;
    end else if (!stall && !halt_q && take_jump &&
                 (jump_addr == cur_pc)) begin
      halt_q <= 1'b1;
    end
  end

  assign frozen = halt_q;
  assign halted = halt_q;
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      cur_pc   <= RESET_PC;
      valid_q  <= 1'b0;
    end else if (!(stall || frozen)) begin
      if (take_jump) begin
        // Word fetched this edge is the fall-through; squash it.
        fetch_pc <= jump_addr;
        valid_q  <= 1'b0;
      end else begin
        cur_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(1);
        valid_q  <= 1'b1;
      end
    end
  end

  assign rom_addr    = fetch_pc;
  assign rom_en      = ~stall & ~frozen;
  assign instruction = rom_data;
  assign pc          = cur_pc;
  assign instr_valid = valid_q & ~frozen;

endmodule
